imm_gen_pipe: RTL

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

---
 rtl/imm_gen_pipe.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator behind a two-entry skid buffer with a registered in_ready.
// Optional feature: define IMM_GEN_CSR_EN to decode CSR immediate forms (csrrwi/csrrsi/csrrci) as fmt 7.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic [TAG_W-1:0] out_tag
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [XLEN-1:0]   r_main_imm;
    logic [2:0]        r_main_fmt;
    logic [TAG_W-1:0]  r_main_tag;
    logic [XLEN-1:0]   r_skid_imm;
    logic [2:0]        r_skid_fmt;
    logic [TAG_W-1:0]  r_skid_tag;

    logic [6:0]        w_opcode;
    logic [2:0]        w_funct3;
    logic              w_is_shift;
    logic [XLEN-1:0]   w_imm;
    logic [2:0]        w_fmt;
    logic              w_accept;
    logic              w_deliver;

    assign w_opcode   = in_inst[6:0];
    assign w_funct3   = in_inst[14:12];
    assign w_is_shift = (w_funct3 == 3'b001) || (w_funct3 == 3'b101);

    // Decode is purely combinational on the incoming word; only the result is buffered.
    always_comb begin
        w_imm = '0;
        w_fmt = 3'd0;
        case (w_opcode)
            7'b0000011, 7'b1100111: begin
                w_imm = XLEN'($signed(in_inst[31:20]));
                w_fmt = 3'd1;
            end
            7'b0010011: begin
                if (w_is_shift) begin
                    w_imm = (XLEN == 32) ? XLEN'(in_inst[24:20]) : XLEN'(in_inst[25:20]);
                    w_fmt = 3'd6;
                end else begin
                    w_imm = XLEN'($signed(in_inst[31:20]));
                    w_fmt = 3'd1;
                end
            end
            7'b0011011: begin
                if (XLEN == 64) begin
                    if (w_is_shift) begin
                        w_imm = XLEN'(in_inst[24:20]);
                        w_fmt = 3'd6;
                    end else begin
                        w_imm = XLEN'($signed(in_inst[31:20]));
                        w_fmt = 3'd1;
                    end
                end
            end
            7'b0100011: begin
                w_imm = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
                w_fmt = 3'd2;
            end
            7'b1100011: begin
                w_imm = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
                w_fmt = 3'd3;
            end
            7'b0110111, 7'b0010111: begin
                w_imm = XLEN'($signed({in_inst[31:12], 12'b0}));
                w_fmt = 3'd4;
            end
            7'b1101111: begin
                w_imm = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));
                w_fmt = 3'd5;
            end
`ifdef IMM_GEN_CSR_EN
            7'b1110011: begin
                if (w_funct3[2] && (w_funct3[1:0] != 2'b00)) begin
                    w_imm = XLEN'(in_inst[19:15]);
                    w_fmt = 3'd7;
                end
            end
`endif
            default: begin
            end
        endcase
    end

    assign w_accept  = in_valid && r_in_ready;
    assign w_deliver = r_out_valid && out_ready;

    // in_ready is derived from the next state so it never depends combinationally on out_ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_main_imm  <= '0;
            r_main_fmt  <= 3'd0;
            r_main_tag  <= '0;
            r_skid_imm  <= '0;
            r_skid_fmt  <= 3'd0;
            r_skid_tag  <= '0;
        end else if (flush) begin
            r_state     <= EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        r_main_imm  <= w_imm;
                        r_main_fmt  <= w_fmt;
                        r_main_tag  <= in_tag;
                        r_state     <= ONE;
                        r_out_valid <= 1'b1;
                    end
                end
                ONE: begin
                    if (w_accept && !w_deliver) begin
                        r_skid_imm <= w_imm;
                        r_skid_fmt <= w_fmt;
                        r_skid_tag <= in_tag;
                        r_state    <= TWO;
                        r_in_ready <= 1'b0;
                    end else if (w_accept && w_deliver) begin
                        r_main_imm <= w_imm;
                        r_main_fmt <= w_fmt;
                        r_main_tag <= in_tag;
                    end else if (w_deliver) begin
                        r_state     <= EMPTY;
                        r_out_valid <= 1'b0;
                    end
                end
                TWO: begin
                    if (w_deliver) begin
                        r_main_imm <= r_skid_imm;
                        r_main_fmt <= r_skid_fmt;
                        r_main_tag <= r_skid_tag;
                        r_state    <= ONE;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= EMPTY;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_imm   = r_main_imm;
    assign out_fmt   = r_main_fmt;
    assign out_tag   = r_main_tag;

endmodule
